// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_pkg
// Description : Shared constants, the unloader state type and the
//               bit-reverse helper for the NTT coefficient store.
// Contents    : WIDTH, DEPTH, LANES, ADDR_WIDTH constants
//               unload_state_t  - coefficient unloader FSM states
//               bitrev()        - reverse an ADDR_WIDTH-bit address
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

    localparam int WIDTH      = 12;
    localparam int DEPTH      = 256;
    localparam int LANES      = 16;
    localparam int ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } unload_state_t;

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = a[ADDR_WIDTH-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coef_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : coef_addr_gen
// Description : Purely combinational read-address generator. Lane k of the
//               output addresses coefficient (row * LANES + k), truncated to
//               ADDR_WIDTH bits.
// Macro       : COEF_UNLOADER_BITREV_EN - when defined, every address is
//               bit-reversed over ADDR_WIDTH bits so the stream comes out in
//               natural order from a bit-reversed store.
// Ports       : i_row_ptr [PTR_WIDTH]          - row being addressed
//               o_raddr   [LANES*ADDR_WIDTH]   - lane k at [k*ADDR_WIDTH +:]
// Revision    : 1.0 - initial release
// ============================================================================
module coef_addr_gen #(
    parameter int LANES      = ntt_pkg::LANES,
    parameter int ADDR_WIDTH = ntt_pkg::ADDR_WIDTH,
    parameter int PTR_WIDTH  = 5
) (
    input  logic [PTR_WIDTH-1:0]        i_row_ptr,
    output logic [LANES*ADDR_WIDTH-1:0] o_raddr
);
    import ntt_pkg::*;

    localparam int LANE_WIDTH = $clog2(LANES);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [LANE_WIDTH-1:0] c_lane = LANE_WIDTH'(k);
        logic [ADDR_WIDTH-1:0] w_nat;

        // LANES is a power of two, so row*LANES + k is a concatenation.
        assign w_nat = ADDR_WIDTH'({i_row_ptr, c_lane});

`ifdef COEF_UNLOADER_BITREV_EN
        assign o_raddr[k*ADDR_WIDTH +: ADDR_WIDTH] = bitrev(w_nat);
`else
        assign o_raddr[k*ADDR_WIDTH +: ADDR_WIDTH] = w_nat;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/coef_unloader.sv
`default_nettype none
// ============================================================================
// Module      : coef_unloader
// Description : Streams a DEPTH-coefficient polynomial out of the 16-lane
//               register file, one row fetch per LANES beats, onto a
//               valid/ready stream in index order.
// Macro       : COEF_UNLOADER_BITREV_EN - bit-reversed read addressing
//               (handled inside coef_addr_gen).
// Ports       : clk_i, rst_i (sync, active-high)
//               start_i            - start request, honoured only when idle
//               busy_o / done_o    - run in progress / one-cycle completion
//               raddr_o / rdata_i  - LANES combinational read ports
//               m_data_o, m_valid_o, m_ready_i, m_last_o - output stream
// Revision    : 1.0 - initial release
// ============================================================================
module coef_unloader #(
    parameter int WIDTH      = ntt_pkg::WIDTH,
    parameter int DEPTH      = ntt_pkg::DEPTH,
    parameter int LANES      = ntt_pkg::LANES,
    parameter int ADDR_WIDTH = ntt_pkg::ADDR_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [LANES*ADDR_WIDTH-1:0] raddr_o,
    input  logic [LANES*WIDTH-1:0]      rdata_i,
    output logic [WIDTH-1:0]            m_data_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic                        m_last_o
);
    import ntt_pkg::*;

    localparam int ROWS       = DEPTH / LANES;
    localparam int PTR_WIDTH  = $clog2(ROWS) + 1;
    localparam int LANE_WIDTH = $clog2(LANES);
    localparam logic [PTR_WIDTH-1:0]  c_last_row  = PTR_WIDTH'(ROWS);
    localparam logic [LANE_WIDTH-1:0] c_last_lane = LANE_WIDTH'(LANES - 1);

    unload_state_t         r_state;
    unload_state_t         w_state_next;
    logic [PTR_WIDTH-1:0]  r_row_ptr;
    logic [LANE_WIDTH-1:0] r_lane_ctr;
    logic [WIDTH-1:0]      r_row_buf [LANES];

    logic w_first_load;
    logic w_next_load;
    logic w_lane_step;
    logic w_clear;
    logic w_last_lane;
    logic w_last_row;

    coef_addr_gen #(
        .LANES      (LANES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_addr_gen (
        .i_row_ptr (r_row_ptr),
        .o_raddr   (raddr_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_first_load = 1'b0;
        w_next_load  = 1'b0;
        w_lane_step  = 1'b0;
        w_clear      = 1'b0;
        w_last_lane  = (r_lane_ctr == c_last_lane);
        w_last_row   = (r_row_ptr == c_last_row);
        m_valid_o    = 1'b0;
        done_o       = 1'b0;
        busy_o       = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_first_load = 1'b1;
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    if (!w_last_lane) begin
                        w_lane_step = 1'b1;
                    end else if (!w_last_row) begin
                        // Next row is already on raddr_o; capture it on the
                        // same edge that retires the final lane: no bubble.
                        w_next_load = 1'b1;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                done_o       = 1'b1;
                w_clear      = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        m_last_o = m_valid_o && w_last_row && w_last_lane;
        m_data_o = m_valid_o ? r_row_buf[r_lane_ctr] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_row_ptr  <= '0;
            r_lane_ctr <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_row_buf[k] <= '0;
            end
        end else if (w_first_load || w_next_load) begin
            for (int k = 0; k < LANES; k++) begin
                r_row_buf[k] <= rdata_i[k*WIDTH +: WIDTH];
            end
            r_row_ptr  <= w_first_load ? PTR_WIDTH'(1) : r_row_ptr + PTR_WIDTH'(1);
            r_lane_ctr <= '0;
        end else if (w_lane_step) begin
            r_lane_ctr <= r_lane_ctr + LANE_WIDTH'(1);
        end else if (w_clear) begin
            // Return to row 0 so the idle address bus presents the first row.
            r_row_ptr  <= '0;
            r_lane_ctr <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coef_unloader.sv
`default_nettype none
// ============================================================================
// Module      : tb_coef_unloader
// Description : Self-checking bench for coef_unloader. A memory model drives
//               the read ports; each accepted start pushes the expected
//               DEPTH-beat stream into a scoreboard queue and a negedge
//               monitor pops and compares every accepted beat.
// Macro       : COEF_UNLOADER_BITREV_EN - expected order follows bit-reversal.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coef_unloader;

    localparam int WIDTH      = 12;
    localparam int DEPTH      = 256;
    localparam int LANES      = 16;
    localparam int ADDR_WIDTH = 8;

    logic                        clk_i = 1'b0;
    logic                        rst_i;
    logic                        start_i;
    logic                        busy_o;
    logic                        done_o;
    logic [LANES*ADDR_WIDTH-1:0] raddr_o;
    logic [LANES*WIDTH-1:0]      rdata_i;
    logic [WIDTH-1:0]            m_data_o;
    logic                        m_valid_o;
    logic                        m_ready_i;
    logic                        m_last_o;

    always #5 clk_i = ~clk_i;

    coef_unloader #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .LANES      (LANES),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .raddr_o   (raddr_o),
        .rdata_i   (rdata_i),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_last_o  (m_last_o)
    );

    // Register file model with optional corruption of the read data.
    logic [WIDTH-1:0] mem [DEPTH];
    logic             perturb;

    always_comb begin
        rdata_i = '0;
        for (int k = 0; k < LANES; k++) begin
            rdata_i[k*WIDTH +: WIDTH] = mem[raddr_o[k*ADDR_WIDTH +: ADDR_WIDTH]]
                                        ^ (perturb ? 12'hA5A : 12'h000);
        end
    end

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t sb_q[$];
    beat_t exp_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int beats    = 0;
    int done_cnt = 0;
    int first_beat_cyc = -1;
    int done_cyc = -1;
    int ready_mode = 0;
    int stall_at   = -1;
    int stall_left = 0;

    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Memory index that stream position i must come from.
    function automatic int ref_addr(input int i);
        int r;
        r = i % DEPTH;
`ifdef COEF_UNLOADER_BITREV_EN
        r = 0;
        for (int b = 0; b < ADDR_WIDTH; b++) begin
            if (((i >> b) & 1) != 0) r = r | (1 << (ADDR_WIDTH - 1 - b));
        end
`endif
        return r;
    endfunction

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = rnd ? WIDTH'($urandom()) : WIDTH'(i);
        end
    endtask

    task automatic push_expected();
        beat_t b;
        for (int i = 0; i < DEPTH; i++) begin
            b.last = (i == DEPTH - 1);
            b.data = mem[ref_addr(i)];
            sb_q.push_back(b);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Ready / perturbation driver, updated just after each rising edge.
    initial begin
        m_ready_i = 1'b1;
        perturb   = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (stall_left == 0 && stall_at >= 0 && beats == stall_at) begin
                stall_left = 5;
                stall_at   = -1;
            end
            if (stall_left > 0) begin
                m_ready_i = 1'b0;
                perturb   = 1'b1;
                stall_left--;
            end else begin
                perturb = 1'b0;
                case (ready_mode)
                    1:       m_ready_i = ~m_ready_i;
                    2:       m_ready_i = 1'($urandom_range(0, 1));
                    default: m_ready_i = 1'b1;
                endcase
            end
        end
    end

    // Monitor: sample at the falling edge, compare accepted beats.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (m_valid_o) chk("busy_while_valid", 32'(busy_o), 32'd1);
                if (prev_stall && m_valid_o) begin
                    chk("stall_hold_data", 32'(m_data_o), 32'(prev_data));
                    chk("stall_hold_last", 32'(m_last_o), 32'(prev_last));
                end
                if (m_valid_o && m_ready_i) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got data 0x%0h, expected no beat (cycle %0d)",
                                 m_data_o, cyc);
                    end else begin
                        exp_b = sb_q.pop_front();
                        chk($sformatf("data_beat%0d", beats), 32'(m_data_o), 32'(exp_b.data));
                        chk($sformatf("last_beat%0d", beats), 32'(m_last_o), 32'(exp_b.last));
                    end
                    if (beats == 0) first_beat_cyc = cyc;
                    beats++;
                end
                if (done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = m_valid_o && !m_ready_i;
                prev_data  = m_data_o;
                prev_last  = m_last_o;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic start_run(output int s);
        beats          = 0;
        first_beat_cyc = -1;
        push_expected();
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        s = cyc;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (beats < n && k < budget) begin
            @(negedge clk_i);
            #1;
            k++;
        end
        chk($sformatf("reach_beat%0d", n), 32'(beats >= n), 32'd1);
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk_i);
            #1;
            k++;
        end
        chk("done_seen", 32'(done_cnt > d0), 32'd1);
    endtask

    task automatic finish_run(input int d0);
        repeat (5) @(negedge clk_i);
        chk("single_done", 32'(done_cnt - d0), 32'd1);
        chk("queue_drained", 32'(sb_q.size()), 32'd0);
        chk("idle_after_done", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s;
        int d0;
        rst_i   = 1'b1;
        start_i = 1'b0;
        fill_mem(1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset state
        chk("reset_valid", 32'(m_valid_o), 32'd0);
        chk("reset_last",  32'(m_last_o),  32'd0);
        chk("reset_busy",  32'(busy_o),    32'd0);
        chk("reset_done",  32'(done_o),    32'd0);
        chk("reset_data",  32'(m_data_o),  32'd0);
        for (int k = 0; k < LANES; k++) begin
            chk($sformatf("reset_raddr%0d", k), 32'(raddr_o[k*ADDR_WIDTH +: ADDR_WIDTH]),
                32'(ref_addr(k)));
        end

        // Run 1: ready always high, exact cycle timing.
        ready_mode = 0;
        d0 = done_cnt;
        start_run(s);
        wait_done(d0, 2000);
        chk("first_beat_cycle", 32'(first_beat_cyc), 32'(s));
        chk("done_cycle", 32'(done_cyc), 32'(s + DEPTH));
        @(negedge clk_i);
        chk("busy_low_after_done", 32'(busy_o), 32'd0);
        chk("done_one_cycle", 32'(done_o), 32'd0);
        finish_run(d0);

        // Run 2: ready toggling every cycle.
        ready_mode = 1;
        d0 = done_cnt;
        start_run(s);
        wait_done(d0, 4000);
        finish_run(d0);

        // Run 3: random ready, random memory contents.
        fill_mem(1'b1);
        ready_mode = 2;
        d0 = done_cnt;
        start_run(s);
        wait_done(d0, 4000);
        finish_run(d0);

        // Run 4: 5-cycle stall on beat 15 with corrupted read data.
        fill_mem(1'b0);
        ready_mode = 0;
        stall_at   = 15;
        d0 = done_cnt;
        start_run(s);
        wait_done(d0, 2000);
        finish_run(d0);

        // Run 5: start pulsed mid-stream must be ignored.
        fill_mem(1'b1);
        ready_mode = 2;
        d0 = done_cnt;
        start_run(s);
        wait_beats(100, 2000);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done(d0, 4000);
        finish_run(d0);

        // Run 6: reset at beat 40, then a clean restart.
        fill_mem(1'b0);
        ready_mode = 0;
        d0 = done_cnt;
        start_run(s);
        wait_beats(40, 2000);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sb_q.delete();
        chk("rst_mid_valid", 32'(m_valid_o), 32'd0);
        chk("rst_mid_busy",  32'(busy_o),    32'd0);
        chk("rst_mid_raddr1", 32'(raddr_o[ADDR_WIDTH +: ADDR_WIDTH]), 32'(ref_addr(1)));
        d0 = done_cnt;
        start_run(s);
        wait_done(d0, 2000);
        chk("restart_first_beat_cycle", 32'(first_beat_cyc), 32'(s));
        finish_run(d0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coef_unloader.md
# coef_unloader

Streaming reader for the 16-lane NTT coefficient register file. On `start` it fetches the polynomial one 16-coefficient row per fetch through the register file's 16 combinational read ports. It then serialises the coefficients onto a valid/ready output stream, one coefficient per beat, in index order 0..DEPTH-1. It sits between the coefficient store and the host/DMA result path and is the read-side counterpart of the parallel write path.

## Interface
Parameters:
- `WIDTH`, 12: coefficient width in bits.
- `DEPTH`, 256: coefficients per polynomial.
- `LANES`, 16: read ports per fetch.
- `ADDR_WIDTH`, 8: address width; equals $clog2(DEPTH).

Ports:
- `clk_i`, input, 1: clock. The block has a single clock.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `start_i`, input, 1: start request. Sampled only in IDLE.
- `busy_o`, output, 1: high from the cycle after start is accepted until done.
- `done_o`, output, 1: one-cycle pulse after the final beat is accepted.
- `raddr_o`, output, LANES*ADDR_WIDTH: read addresses. Lane k occupies `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `rdata_i`, input, LANES*WIDTH: combinational read data. Lane k occupies `[k*WIDTH +: WIDTH]`.
- `m_data_o`, output, WIDTH: stream coefficient.
- `m_valid_o`, output, 1: stream valid.
- `m_ready_i`, input, 1: stream ready.
- `m_last_o`, output, 1: high on beat DEPTH-1 only.

## Operation
- Internal state:
  - `row_ptr`: next row to load, $clog2(DEPTH/LANES)+1 bits.
  - `lane_ctr`: 0..LANES-1.
  - `row_buf`: LANES×WIDTH row buffer.
  - FSM with states IDLE, DRAIN, DONE.
- Address generation: `raddr_o` lane k is always `addr(row_ptr, k)`, where `addr(r, k) = r*LANES + k` truncated to ADDR_WIDTH.
- IDLE:
  - `row_ptr` = 0.
  - On `start_i`: `row_buf` <= `rdata_i`, `row_ptr` <= 1, `lane_ctr` <= 0, go to DRAIN.
- DRAIN:
  - `m_valid_o` = 1 and `m_data_o` = `row_buf[lane_ctr]`.
  - On a handshake (`m_valid_o && m_ready_i`) with `lane_ctr` < LANES-1: `lane_ctr` increments.
  - On a handshake with `lane_ctr` = LANES-1 and `row_ptr` < DEPTH/LANES: `row_buf` <= `rdata_i`, `row_ptr`++, `lane_ctr` <= 0.
  - On a handshake with `lane_ctr` = LANES-1 and `row_ptr` = DEPTH/LANES: go to DONE.
- DONE: `done_o` = 1 for one cycle, then go to IDLE.
- `m_last_o` = (`row_ptr` == DEPTH/LANES) && (`lane_ctr` == LANES-1) && DRAIN.
- `start_i` is ignored outside IDLE.
- The register file must not be written while `busy_o` is high; this is the caller's responsibility. Each row is sampled only at its load edge.

## Timing
Reset values:
- `m_valid_o`, `m_last_o`, `busy_o`, `done_o` = 0.
- `m_data_o` = 0.
- `row_ptr`, `lane_ctr` = 0, so `raddr_o` = row 0 addresses.
- FSM = IDLE.

Cycle behaviour:
- Latency: start accepted in cycle 0; first valid beat in cycle 1.
- Row reloads happen at the handshake edge, so there are no bubbles. With `m_ready_i` held high, DEPTH beats occupy cycles 1..DEPTH and `done_o` pulses in cycle DEPTH+1.
- Backpressure: while `m_valid_o && !m_ready_i`, `m_data_o` and `m_last_o` hold stable. `rdata_i` changes are not visible on the stream.
- A stall on the last lane of a row delays the next row fetch until the handshake.
- `busy_o` = (state != IDLE).
- Reset mid-run: at the reset edge all outputs take their reset values. The next start restarts from coefficient 0.

## Configuration
- `COEF_UNLOADER_BITREV_EN` defined: `addr(r, k)` = bit-reverse over ADDR_WIDTH bits of (r*LANES + k). The stream then emits memory in bit-reversed order, natural-ordering the NTT output. Reset `raddr_o` lane k = bitrev(k).
- Not defined: natural addressing as in Operation.
- Handshake and timing are identical in both builds.

## Structure
- Shared package `ntt_pkg`:
  - WIDTH, DEPTH, LANES, ADDR_WIDTH constants.
  - `unload_state_t` enum (IDLE, DRAIN, DONE).
  - `bitrev` function.
- One sub-module, `coef_addr_gen`: purely combinational. Maps `row_ptr` to the LANES addresses and contains the macro-controlled mapping.

## Test plan
- Memory[i] = i, `m_ready_i` = 1, pulse start → stream 0..255 on cycles 1..256, `m_last_o` only with data 255, `done_o` at cycle 257, `busy_o` low at cycle 258.
- `m_ready_i` toggles 1/0 every cycle (pseudo-random in a second run) → sequence 0..255 intact, data held during every stall.
- Ready low for 5 cycles at beat 15 while `rdata_i` is perturbed → beat 15 data = 15 held, beat 16 = 16.
- `start_i` pulsed at beat 100 → ignored, no restart, single `done_o`.
- `rst_i` at beat 40 → next cycle `m_valid_o` = 0 and `busy_o` = 0; a new start emits 0 first.
- `COEF_UNLOADER_BITREV_EN` with memory[i] = i → stream 0, 128, 64, 192, 32, …, ending 255 with `m_last_o`.
